// File: rtl/mii_tx_lane_framer_if.sv
// Beat stream from the MAC frame generator into mii_tx_lane_framer.
// The optional i_err sideband exists only when MII_TX_ERR_EN is defined.
interface mii_tx_lane_framer_if #(
    parameter int LANES = 8
);
    logic [8*LANES-1:0] i_data;
    logic [LANES-1:0]   i_keep;
    logic               i_valid;
    logic               i_last;
    logic               o_ready;
`ifdef MII_TX_ERR_EN
    logic               i_err;

    modport master (output i_data, i_keep, i_valid, i_last, i_err, input o_ready);
    modport slave  (input i_data, i_keep, i_valid, i_last, i_err, output o_ready);
`else
    modport master (output i_data, i_keep, i_valid, i_last, input o_ready);
    modport slave  (input i_data, i_keep, i_valid, i_last, output o_ready);
`endif
endinterface

// File: rtl/mii_tx_lane_framer.sv
// LANES-byte MII/XGMII-style transmit framer: start/preamble/SFD, terminate, IFG, underrun coding, stats.
// Define MII_TX_ERR_EN to add the i_err sideband that error-codes the data lanes of an accepted beat.
module mii_tx_lane_framer #(
    parameter int LANES     = 8,
    parameter int IFG_BYTES = 12,
    parameter int MIN_FRAME = 64
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    mii_tx_lane_framer_if.slave  bus,
    output logic [8*LANES-1:0]   o_txd,
    output logic [LANES-1:0]     o_txc,
    output logic                 o_busy,
    output logic                 o_runt,
    output logic                 o_underrun,
    output logic [31:0]          o_frame_cnt
);
    localparam int PRE_BEATS = 8 / LANES;
    localparam int IFG_BEATS = (IFG_BYTES + LANES - 1) / LANES;
    localparam int IFG_LAST  = (IFG_BEATS > 0) ? IFG_BEATS - 1 : 0;

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_PRE   = 8'h55;
    localparam logic [7:0] C_SFD   = 8'hD5;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERR   = 8'hFE;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_lanes_check
        $error("mii_tx_lane_framer: LANES must be 1, 2, 4 or 8");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_TERM, ST_IFG} state_t;

    state_t              state, state_nxt;
    logic [2:0]          pre_cnt;
    logic [15:0]         ifg_cnt;
    logic [15:0]         byte_cnt;
    logic [31:0]         k;
    logic                keep_run;
    logic                full_last;
    logic                accept;
    logic                data_err;
    logic [16:0]         cnt_add;
    logic [15:0]         cnt_sat;
    logic [31:0]         pre_base;
    logic                runt_last;
    logic [8*LANES-1:0]  txd_nxt;
    logic [LANES-1:0]    txc_nxt;
    logic                runt_nxt, underrun_nxt, term_nxt;

`ifdef MII_TX_ERR_EN
    assign data_err = bus.i_err;
`else
    assign data_err = 1'b0;
`endif

    assign accept    = (state == ST_DATA) && bus.i_valid;
    assign bus.o_ready = (state == ST_DATA);
    assign o_busy    = (state != ST_IDLE);
    assign full_last = (k == 32'(LANES));
    assign cnt_add   = {1'b0, byte_cnt} + 17'(LANES);
    assign cnt_sat   = cnt_add[16] ? 16'hFFFF : cnt_add[15:0];
    assign runt_last = (32'(byte_cnt) + k) < 32'(MIN_FRAME);
    assign pre_base  = 32'(pre_cnt) * 32'(LANES);

    // Leading ones of i_keep; anything above the first zero is ignored.
    always_comb begin
        k = '0;
        keep_run = 1'b1;
        for (int unsigned n = 0; n < LANES; n++) begin
            if (keep_run && bus.i_keep[n]) k = k + 32'd1;
            else                           keep_run = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (bus.i_valid) state_nxt = ST_PREAMBLE;
            ST_PREAMBLE: if (pre_cnt == 3'(PRE_BEATS - 1)) state_nxt = ST_DATA;
            ST_DATA:     if (accept && bus.i_last) state_nxt = full_last ? ST_TERM : ST_IFG;
            ST_TERM:     state_nxt = ST_IFG;
            ST_IFG:      if (ifg_cnt == 16'(IFG_LAST)) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt  <= '0;
            ifg_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            pre_cnt <= (state == ST_PREAMBLE) ? pre_cnt + 3'd1 : '0;
            ifg_cnt <= (state == ST_IFG) ? ifg_cnt + 16'd1 : '0;
            if (state == ST_PREAMBLE)                        byte_cnt <= '0;
            else if (accept && (!bus.i_last || full_last))   byte_cnt <= cnt_sat;
        end
    end

    always_comb begin
        txd_nxt      = {LANES{C_IDLE}};
        txc_nxt      = '1;
        runt_nxt     = 1'b0;
        underrun_nxt = 1'b0;
        term_nxt     = 1'b0;
        unique case (state)
            ST_PREAMBLE: begin
                for (int unsigned n = 0; n < LANES; n++) begin
                    if (pre_base + n == 32'd0)      txd_nxt[8*n +: 8] = C_START;
                    else if (pre_base + n == 32'd7) txd_nxt[8*n +: 8] = C_SFD;
                    else                            txd_nxt[8*n +: 8] = C_PRE;
                    txc_nxt[n] = (pre_base + n == 32'd0);
                end
            end
            ST_DATA: begin
                if (!bus.i_valid) begin
                    txd_nxt      = {LANES{C_ERR}};
                    underrun_nxt = 1'b1;
                end else begin
                    // A full last beat codes like a mid-frame beat; its terminate follows in ST_TERM.
                    for (int unsigned n = 0; n < LANES; n++) begin
                        if (!bus.i_last || full_last || n < k) begin
                            txd_nxt[8*n +: 8] = data_err ? C_ERR : bus.i_data[8*n +: 8];
                            txc_nxt[n]        = data_err;
                        end else if (n == k) begin
                            txd_nxt[8*n +: 8] = C_TERM;
                        end
                    end
                    if (bus.i_last && !full_last) begin
                        runt_nxt = runt_last;
                        term_nxt = 1'b1;
                    end
                end
            end
            ST_TERM: begin
                txd_nxt[7:0] = C_TERM;
                runt_nxt     = 32'(byte_cnt) < 32'(MIN_FRAME);
                term_nxt     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_txd       <= {LANES{C_IDLE}};
            o_txc       <= '1;
            o_runt      <= 1'b0;
            o_underrun  <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_txd       <= txd_nxt;
            o_txc       <= txc_nxt;
            o_runt      <= runt_nxt;
            o_underrun  <= underrun_nxt;
            o_frame_cnt <= o_frame_cnt + 32'(term_nxt);
        end
    end
endmodule

// File: tb/tb_mii_tx_lane_framer.sv
// Scoreboard bench for mii_tx_lane_framer: an 8-lane instance for framing/IFG/underrun/runt
// and a 4-lane instance for preamble split and asynchronous mid-frame reset.
module tb_mii_tx_lane_framer;
    typedef struct {
        logic [63:0] txd;
        logic [7:0]  txc;
        logic        runt;
        logic        underrun;
    } beat_t;

    logic clk = 1'b0;
    logic rst8_n = 1'b0;
    logic rst4_n = 1'b0;
    always #5 clk = ~clk;

    mii_tx_lane_framer_if #(.LANES(8)) bus8();
    mii_tx_lane_framer_if #(.LANES(4)) bus4();

    logic [63:0] o_txd8;
    logic [7:0]  o_txc8;
    logic        o_busy8, o_runt8, o_underrun8;
    logic [31:0] o_frame_cnt8;
    logic [31:0] o_txd4;
    logic [3:0]  o_txc4;
    logic        o_busy4, o_runt4, o_underrun4;
    logic [31:0] o_frame_cnt4;

    mii_tx_lane_framer #(.LANES(8), .IFG_BYTES(12), .MIN_FRAME(64)) dut8 (
        .clk(clk), .i_rst_n(rst8_n), .bus(bus8),
        .o_txd(o_txd8), .o_txc(o_txc8), .o_busy(o_busy8), .o_runt(o_runt8),
        .o_underrun(o_underrun8), .o_frame_cnt(o_frame_cnt8)
    );

    mii_tx_lane_framer #(.LANES(4), .IFG_BYTES(12), .MIN_FRAME(64)) dut4 (
        .clk(clk), .i_rst_n(rst4_n), .bus(bus4),
        .o_txd(o_txd4), .o_txc(o_txc4), .o_busy(o_busy4), .o_runt(o_runt4),
        .o_underrun(o_underrun4), .o_frame_cnt(o_frame_cnt4)
    );

    int total = 0;
    int bad = 0;
    beat_t q8[$];
    beat_t q4[$];
    int gap_q[$];
    int idle_run8 = 0;
    int fcnt8 = 0;

    function automatic beat_t mk(input logic [63:0] txd, input logic [7:0] txc,
                                 input logic runt, input logic underrun);
        beat_t b;
        b.txd = txd; b.txc = txc; b.runt = runt; b.underrun = underrun;
        return b;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 8-lane monitor: idle beats must carry no flags, every other beat pops the scoreboard.
    always @(negedge clk) begin
        if (rst8_n) begin
            if (o_txd8 == {8{8'h07}} && o_txc8 == 8'hFF) begin
                idle_run8++;
                chk("idle_flags8", {78'b0, o_runt8, o_underrun8}, 80'b0);
            end else begin
                if (o_txd8[7:0] == 8'hFB && o_txc8[0] && gap_q.size() > 0)
                    chk("ifg_gap", 80'(idle_run8), 80'(gap_q.pop_front()));
                idle_run8 = 0;
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat8: got txd=%h txc=%h expected no beat", o_txd8, o_txc8);
                end else begin
                    beat_t e;
                    e = q8.pop_front();
                    chk("beat8", {6'b0, o_txd8, o_txc8, o_runt8, o_underrun8},
                        {6'b0, e.txd, e.txc, e.runt, e.underrun});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst4_n && !(o_txd4 == {4{8'h07}} && o_txc4 == 4'hF)) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_beat4: got txd=%h txc=%h expected no beat", o_txd4, o_txc4);
            end else begin
                beat_t e;
                e = q4.pop_front();
                chk("beat4", {6'b0, 32'b0, o_txd4, 4'b0, o_txc4, o_runt4, o_underrun4},
                    {6'b0, e.txd, e.txc, e.runt, e.underrun});
            end
        end
    end

    task automatic wait_slot(input bit four);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (four ? bus4.o_ready : bus8.o_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ready_timeout: got o_ready=0 expected 1 within 60 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit four);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((four ? q4.size() : q8.size()) == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending beats expected 0",
                     four ? q4.size() : q8.size());
        end
    endtask

    // nbeats beats, last beat carrying klast bytes (keep given separately, may have junk above the first zero).
    task automatic send8(input int nbeats, input int klast, input logic [7:0] keep,
                         input int ubeat, input int ugaps, input logic [7:0] seed,
                         input bit hold, input int gap_exp);
        logic [63:0] d, e;
        int nbytes;
        bit is_last;
        nbytes = (nbeats - 1) * 8 + klast;
        if (gap_exp >= 0) gap_q.push_back(gap_exp);
        q8.push_back(mk(64'hD5555555555555FB, 8'h01, 1'b0, 1'b0));
        for (int b = 0; b < nbeats; b++) begin
            if (b == ubeat) begin
                for (int g = 0; g < ugaps; g++) begin
                    bus8.i_valid = 1'b0;
                    q8.push_back(mk({8{8'hFE}}, 8'hFF, 1'b0, 1'b1));
                    wait_slot(1'b0);
                end
            end
            for (int n = 0; n < 8; n++) d[8*n +: 8] = seed + 8'(b * 8 + n);
            is_last = (b == nbeats - 1);
            bus8.i_valid = 1'b1;
            bus8.i_data  = d;
            bus8.i_last  = is_last;
            bus8.i_keep  = is_last ? keep : 8'h5A;
            if (is_last && klast < 8) begin
                e = d;
                for (int n = klast; n < 8; n++) e[8*n +: 8] = (n == klast) ? 8'hFD : 8'h07;
                q8.push_back(mk(e, 8'(8'hFF << klast), nbytes < 64, 1'b0));
            end else begin
                q8.push_back(mk(d, 8'h00, 1'b0, 1'b0));
            end
            if (is_last && klast == 8)
                q8.push_back(mk(64'h07070707070707FD, 8'hFF, nbytes < 64, 1'b0));
            wait_slot(1'b0);
        end
        if (!hold) begin
            bus8.i_valid = 1'b0;
            bus8.i_last  = 1'b0;
        end
        fcnt8++;
    endtask

    initial begin
        bus8.i_valid = 1'b0; bus8.i_last = 1'b0; bus8.i_keep = '0; bus8.i_data = '0;
        bus4.i_valid = 1'b0; bus4.i_last = 1'b0; bus4.i_keep = '0; bus4.i_data = '0;
`ifdef MII_TX_ERR_EN
        bus8.i_err = 1'b0;
        bus4.i_err = 1'b0;
`endif
        #22;
        rst8_n = 1'b1;
        rst4_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_txd",  80'(o_txd8), 80'h0707070707070707);
        chk("rst_txc",  80'(o_txc8), 80'hFF);
        chk("rst_flags", {76'b0, bus8.o_ready, o_busy8, o_runt8, o_underrun8}, 80'b0);
        chk("rst_cnt",  80'(o_frame_cnt8), 80'd0);

        // 64-byte frame, full last beat -> TERM state
        send8(8, 8, 8'hFF, -1, 0, 8'h10, 1'b0, -1);
        drain(1'b0);
        chk("cnt_64B", 80'(o_frame_cnt8), 80'(fcnt8));
        // 68 bytes, keep 0x0F -> terminate in lane 4
        send8(9, 4, 8'h0F, -1, 0, 8'h40, 1'b0, -1);
        drain(1'b0);
        chk("cnt_68B", 80'(o_frame_cnt8), 80'(fcnt8));
        // 40-byte runt
        send8(5, 8, 8'hFF, -1, 0, 8'h80, 1'b0, -1);
        drain(1'b0);
        // back-to-back: 3 idle beats between terminate and next start
        send8(2, 8, 8'hFF, -1, 0, 8'h20, 1'b1, -1);
        send8(8, 8, 8'hFF, -1, 0, 8'h30, 1'b0, 3);
        drain(1'b0);
        chk("cnt_b2b", 80'(o_frame_cnt8), 80'(fcnt8));
        // two underrun beats mid-frame
        send8(8, 8, 8'hFF, 3, 2, 8'h90, 1'b0, -1);
        drain(1'b0);
        // k == 0 last beat (64 bytes, not runt), junk keep above first zero, 63-byte runt
        send8(9, 0, 8'h00, -1, 0, 8'hA0, 1'b0, -1);
        send8(8, 3, 8'hA7, -1, 0, 8'hB0, 1'b0, -1);
        send8(8, 7, 8'h7F, -1, 0, 8'hC0, 1'b0, -1);
        drain(1'b0);
        chk("cnt_all8", 80'(o_frame_cnt8), 80'(fcnt8));

        // 4-lane: preamble split into two beats, then asynchronous reset mid-DATA
        q4.push_back(mk(64'h555555FB, 8'h1, 1'b0, 1'b0));
        q4.push_back(mk(64'hD5555555, 8'h0, 1'b0, 1'b0));
        bus4.i_valid = 1'b1; bus4.i_last = 1'b0; bus4.i_keep = 4'hF; bus4.i_data = 32'h03020100;
        q4.push_back(mk(64'h03020100, 8'h0, 1'b0, 1'b0));
        wait_slot(1'b1);
        bus4.i_data = 32'h07060504;
        q4.push_back(mk(64'h07060504, 8'h0, 1'b0, 1'b0));
        wait_slot(1'b1);
        @(negedge clk);
        chk("busy4_mid", 80'(o_busy4), 80'd1);
        #2;
        rst4_n = 1'b0;
        bus4.i_valid = 1'b0;
        q4.delete();
        #1;
        chk("rst4_txd", 80'(o_txd4), 80'h07070707);
        chk("rst4_txc", 80'(o_txc4), 80'hF);
        chk("rst4_state", {78'b0, o_busy4, bus4.o_ready}, 80'b0);
        chk("rst4_cnt", 80'(o_frame_cnt4), 80'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst4_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst4_idle", {40'b0, o_txd4, 4'b0, o_txc4}, {40'b0, 32'h07070707, 8'h0F});
        chk("post_rst4_busy", 80'(o_busy4), 80'd0);

        // fresh 8-byte 4-lane frame: TERM beat flags runt
        q4.push_back(mk(64'h555555FB, 8'h1, 1'b0, 1'b0));
        q4.push_back(mk(64'hD5555555, 8'h0, 1'b0, 1'b0));
        bus4.i_valid = 1'b1; bus4.i_last = 1'b0; bus4.i_data = 32'hDDCCBBAA;
        q4.push_back(mk(64'hDDCCBBAA, 8'h0, 1'b0, 1'b0));
        wait_slot(1'b1);
        bus4.i_last = 1'b1; bus4.i_data = 32'h44332211;
        q4.push_back(mk(64'h44332211, 8'h0, 1'b0, 1'b0));
        q4.push_back(mk(64'h070707FD, 8'hF, 1'b1, 1'b0));
        wait_slot(1'b1);
        bus4.i_valid = 1'b0; bus4.i_last = 1'b0;
        drain(1'b1);
        chk("cnt4", 80'(o_frame_cnt4), 80'd1);

        repeat (10) @(posedge clk);
        #1;
        if (q8.size() != 0 || q4.size() != 0 || gap_q.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover: got q8=%0d q4=%0d gap=%0d expected all 0",
                     q8.size(), q4.size(), gap_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
